// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution scheduler: default sizes,
// FSM state encoding and the window packing helper.
package conv_pkg;

    localparam int unsigned DefDataSize     = 8;
    localparam int unsigned DefKernelWidth  = 3;
    localparam int unsigned DefKernelLength = 3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StFlush  = 2'd2
    } conv_state_e;

    // Bit offset of window element (row i top->bottom, column j left->right).
    function automatic int unsigned win_offset(input int unsigned i, input int unsigned j,
                                               input int unsigned data_size);
        return (i * DefKernelWidth + j) * data_size;
    endfunction

endpackage

// File: rtl/MAC.sv
// Combinational 3x3 multiply-accumulate: unsigned sum of element-wise
// products plus bias, saturated to the all-ones value of DATA_SIZE bits.
module MAC #(
    parameter int unsigned DATA_SIZE     = 8,
    parameter int unsigned KERNEL_WIDTH  = 3,
    parameter int unsigned KERNEL_LENGTH = 3
) (
    input  logic [DATA_SIZE*KERNEL_WIDTH*KERNEL_LENGTH-1:0] map_in,
    input  logic [DATA_SIZE*KERNEL_WIDTH*KERNEL_LENGTH-1:0] kernel_in,
    input  logic [DATA_SIZE-1:0]                            bias_in,
    output logic [DATA_SIZE-1:0]                            mac_out
);
    localparam int unsigned Taps = KERNEL_WIDTH * KERNEL_LENGTH;
    localparam int unsigned AccW = 2 * DATA_SIZE + $clog2(Taps) + 1;

    logic [AccW-1:0] acc;

    // Full-precision accumulation; no intermediate overflow possible at AccW.
    always_comb begin
        acc = AccW'(bias_in);
        for (int k = 0; k < Taps; k++) begin
            acc = acc + AccW'(map_in[k*DATA_SIZE +: DATA_SIZE])
                      * AccW'(kernel_in[k*DATA_SIZE +: DATA_SIZE]);
        end
    end

    assign mac_out = (acc > AccW'({DATA_SIZE{1'b1}})) ? {DATA_SIZE{1'b1}} : acc[DATA_SIZE-1:0];

endmodule

// File: rtl/conv_line_buffer.sv
// Two column-indexed line buffers holding the previous two image rows.
// Contents are never cleared; rows 0-1 of each frame refill them.
module conv_line_buffer #(
    parameter int unsigned  DATA_SIZE = 8,
    parameter int unsigned  DEPTH     = 8,
    localparam int unsigned IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [IdxW-1:0]      idx_i,
    input  logic [DATA_SIZE-1:0] data_i,
    output logic [DATA_SIZE-1:0] line0_o,
    output logic [DATA_SIZE-1:0] line1_o
);
    logic [DATA_SIZE-1:0] line0_q [DEPTH];
    logic [DATA_SIZE-1:0] line1_q [DEPTH];

    assign line0_o = line0_q[idx_i];
    assign line1_o = line1_q[idx_i];

    // Push the new pixel down the column: line0 -> line1, pixel -> line0.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            line1_q[idx_i] <= line0_q[idx_i];
            line0_q[idx_i] <= data_i;
        end
    end

endmodule

// File: rtl/conv3x3_scheduler.sv
// Streams a raster-ordered feature map through a 3x3 MAC (stride 1, no
// padding) and registers each result behind a valid/ready handshake.
module conv3x3_scheduler
    import conv_pkg::*;
#(
    parameter int unsigned DATA_SIZE     = DefDataSize,
    parameter int unsigned KERNEL_WIDTH  = DefKernelWidth,
    parameter int unsigned KERNEL_LENGTH = DefKernelLength,
    parameter int unsigned MAP_WIDTH     = 8,
    parameter int unsigned MAP_HEIGHT    = 8
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            start,
    input  logic [DATA_SIZE*KERNEL_WIDTH*KERNEL_LENGTH-1:0] kernel_in,
    input  logic [DATA_SIZE-1:0]                            bias_in,
    input  logic                                            pix_valid,
    output logic                                            pix_ready,
    input  logic [DATA_SIZE-1:0]                            pix_data,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [DATA_SIZE-1:0]                            out_data,
    output logic                                            out_last,
    output logic                                            busy,
    output logic                                            done
);
    localparam int unsigned Taps = KERNEL_WIDTH * KERNEL_LENGTH;
    localparam int unsigned ColW = $clog2(MAP_WIDTH);
    localparam int unsigned RowW = $clog2(MAP_HEIGHT);

    conv_state_e                 state_q, state_d;
    logic [ColW-1:0]             col_q, col_d;
    logic [RowW-1:0]             row_q, row_d;
    logic [DATA_SIZE*Taps-1:0]   kernel_q, kernel_d;
    logic [DATA_SIZE-1:0]        bias_q, bias_d;
    logic [DATA_SIZE-1:0]        out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_last_q, out_last_d;
    logic                        done_q, done_d;

    // Two most recent window columns; the third comes straight from the input.
    logic [DATA_SIZE-1:0]        win_q [3][2];
    logic [DATA_SIZE-1:0]        col_new [3];
    logic [DATA_SIZE-1:0]        line0_rd, line1_rd;
    logic [DATA_SIZE*Taps-1:0]   map_in;
    logic [DATA_SIZE-1:0]        mac_out;
    logic                        pix_accept, win_complete, last_pix;

    assign pix_ready    = (state_q == StStream) && (!out_valid_q || out_ready);
    assign pix_accept   = pix_valid && pix_ready;
    assign win_complete = (row_q >= RowW'(2)) && (col_q >= ColW'(2));
    assign last_pix     = (row_q == RowW'(MAP_HEIGHT - 1)) && (col_q == ColW'(MAP_WIDTH - 1));

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

    conv_line_buffer #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (MAP_WIDTH)
    ) u_line_buffer (
        .clk_i   (clk),
        .we_i    (pix_accept),
        .idx_i   (col_q),
        .data_i  (pix_data),
        .line0_o (line0_rd),
        .line1_o (line1_rd)
    );

    assign col_new[0] = line1_rd;
    assign col_new[1] = line0_rd;
    assign col_new[2] = pix_data;

    // The MAC sees the post-shift window so the result registers on the same edge.
    for (genvar gi = 0; gi < 3; gi++) begin : g_pack
        assign map_in[win_offset(gi, 0, DATA_SIZE) +: DATA_SIZE] = win_q[gi][0];
        assign map_in[win_offset(gi, 1, DATA_SIZE) +: DATA_SIZE] = win_q[gi][1];
        assign map_in[win_offset(gi, 2, DATA_SIZE) +: DATA_SIZE] = col_new[gi];
    end

    MAC #(
        .DATA_SIZE     (DATA_SIZE),
        .KERNEL_WIDTH  (KERNEL_WIDTH),
        .KERNEL_LENGTH (KERNEL_LENGTH)
    ) u_mac (
        .map_in    (map_in),
        .kernel_in (kernel_q),
        .bias_in   (bias_q),
        .mac_out   (mac_out)
    );

    // Next-state: frame sequencing, raster counters and the output register.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        kernel_d    = kernel_q;
        bias_d      = bias_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StStream;
                    kernel_d = kernel_in;
                    bias_d   = bias_in;
                    row_d    = '0;
                    col_d    = '0;
                end
            end
            StStream: begin
                if (pix_accept) begin
                    if (col_q == ColW'(MAP_WIDTH - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (win_complete) begin
                        out_valid_d = 1'b1;
                        out_data_d  = mac_out;
                        out_last_d  = last_pix;
                    end
                    if (last_pix) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and output state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            kernel_q    <= '0;
            bias_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            kernel_q    <= kernel_d;
            bias_q      <= bias_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    // Shift the window left by one column on every accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= '0;
                win_q[i][1] <= '0;
            end
        end else if (pix_accept) begin
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= col_new[i];
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_scheduler.sv
// Self-checking bench: a frame-image reference model pushes expected results
// into a scoreboard queue as pixels are accepted; results are popped on each
// output handshake.
module tb_conv3x3_scheduler;

    localparam int unsigned Ds = 8;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 4x4 instance
    logic          start, pix_valid, pix_ready, out_valid, out_ready, out_last, busy, done;
    logic [Ds*9-1:0] kernel_in;
    logic [Ds-1:0] bias_in, pix_data, out_data;

    // 8x8 instance
    logic          start8, pix_valid8, pix_ready8, out_valid8, out_ready8, out_last8, busy8, done8;
    logic [Ds*9-1:0] kernel8;
    logic [Ds-1:0] bias8, pix_data8, out_data8;

    conv3x3_scheduler #(
        .DATA_SIZE (Ds), .KERNEL_WIDTH (3), .KERNEL_LENGTH (3),
        .MAP_WIDTH (W), .MAP_HEIGHT (H)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .kernel_in (kernel_in), .bias_in (bias_in),
        .pix_valid (pix_valid), .pix_ready (pix_ready), .pix_data (pix_data),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
        .out_last (out_last), .busy (busy), .done (done)
    );

    conv3x3_scheduler #(
        .DATA_SIZE (Ds), .KERNEL_WIDTH (3), .KERNEL_LENGTH (3),
        .MAP_WIDTH (8), .MAP_HEIGHT (8)
    ) dut8 (
        .clk (clk), .rst (rst), .start (start8), .kernel_in (kernel8), .bias_in (bias8),
        .pix_valid (pix_valid8), .pix_ready (pix_ready8), .pix_data (pix_data8),
        .out_valid (out_valid8), .out_ready (out_ready8), .out_data (out_data8),
        .out_last (out_last8), .busy (busy8), .done (done8)
    );

    typedef struct packed {
        logic [Ds-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            results;
    int            last_hs_cyc;
    logic [Ds-1:0] img [W*H];
    logic [Ds-1:0] kern [9];
    logic [Ds-1:0] bias;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: window whose bottom-right pixel is (r,c), unsigned, saturating.
    function automatic logic [Ds-1:0] ref_mac(input int r, input int c);
        int acc;
        acc = int'(bias);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                acc += int'(kern[i*3+j]) * int'(img[(r-2+i)*W + (c-2+j)]);
        return (acc > 255) ? 8'hff : acc[7:0];
    endfunction

    task automatic monitor();
        exp_t e;
        if (out_valid && out_ready) begin
            check_eq("result_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("out_data", 32'(out_data), 32'(e.data));
                check_eq("out_last", 32'(out_last), 32'(e.last));
                results++;
                if (out_last) last_hs_cyc = cyc;
            end
        end
    endtask

    task automatic step(output bit acc);
        @(negedge clk);
        acc = pix_valid && pix_ready;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit thr, input bit stall, input bit glitch, input int abort_at);
        int  idx = 0;
        int  guard = 0;
        bit  acc;
        bit  stalled = 0;
        results = 0;
        for (int k = 0; k < 9; k++) kernel_in[k*Ds +: Ds] = kern[k];
        bias_in   = bias;
        start     = 1'b1;
        out_ready = 1'b1;
        step(acc);
        start = 1'b0;
        check_eq("busy_after_start", 32'(busy), 1);
        check_eq("pix_ready_after_start", 32'(pix_ready), 1);
        while (idx < int'(W*H) && guard < 2000) begin
            if (abort_at != 0 && idx == abort_at) begin
                pix_valid = 1'b0;
                rst = 1'b1;
                #1;
                check_eq("rst_pix_ready", 32'(pix_ready), 0);
                check_eq("rst_out_valid", 32'(out_valid), 0);
                check_eq("rst_out_data", 32'(out_data), 0);
                check_eq("rst_out_last", 32'(out_last), 0);
                check_eq("rst_busy", 32'(busy), 0);
                check_eq("rst_done", 32'(done), 0);
                exp_q.delete();
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            if (stall && idx == 11 && !stalled) begin
                stalled   = 1;
                out_ready = 1'b0;
                pix_valid = 1'b1;
                pix_data  = img[idx];
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check_eq("stall_pix_ready", 32'(pix_ready), 0);
                    check_eq("stall_out_valid", 32'(out_valid), 1);
                    check_eq("stall_out_data", 32'(out_data),
                             (exp_q.size() != 0) ? 32'(exp_q[0].data) : 32'hffff_ffff);
                    @(posedge clk);
                    #1;
                end
            end
            pix_valid = thr ? ($urandom_range(3) != 0) : 1'b1;
            pix_data  = img[idx];
            out_ready = thr ? 1'($urandom_range(1)) : 1'b1;
            if (glitch && idx == 5) begin
                start     = 1'b1;
                kernel_in = {9{8'haa}};
                bias_in   = 8'h33;
            end
            step(acc);
            start = 1'b0;
            if (acc) begin
                if (idx / W >= 2 && idx % W >= 2)
                    exp_q.push_back({ref_mac(idx / W, idx % W), 1'(idx == int'(W*H) - 1)});
                idx++;
            end
            guard++;
        end
        pix_valid = 1'b0;
        check_eq("frame_pixels_accepted", idx, W*H);
    endtask

    task automatic finish_frame(input bit thr, input int exp_results);
        int guard = 0;
        bit seen = 0;
        pix_valid = 1'b0;
        while (!seen && guard < 200) begin
            out_ready = thr ? 1'($urandom_range(1)) : 1'b1;
            @(negedge clk);
            monitor();
            if (done) begin
                seen = 1;
                check_eq("done_timing", cyc, last_hs_cyc + 1);
                check_eq("busy_at_done", 32'(busy), 0);
            end
            @(posedge clk);
            #1;
            guard++;
        end
        check_eq("done_seen", 32'(seen), 1);
        check_eq("result_count", results, exp_results);
        check_eq("queue_empty", exp_q.size(), 0);
        out_ready = 1'b1;
    endtask

    task automatic run_frame8();
        int sent = 0;
        int got = 0;
        int guard = 0;
        int e8;
        e8 = 9 * 20 * 80 + 128;
        e8 = (e8 > 255) ? 255 : e8;
        kernel8    = {9{8'd20}};
        bias8      = 8'd128;
        pix_data8  = 8'd80;
        pix_valid8 = 1'b1;
        out_ready8 = 1'b1;
        start8     = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        while ((sent < 64 || !done8) && guard < 400) begin
            @(negedge clk);
            if (pix_valid8 && pix_ready8) sent++;
            if (out_valid8 && out_ready8) begin
                got++;
                check_eq("f8_data", 32'(out_data8), e8);
                check_eq("f8_last", 32'(out_last8), 32'(got == 36));
            end
            @(posedge clk);
            #1;
            if (sent == 64) pix_valid8 = 1'b0;
            guard++;
        end
        check_eq("f8_count", got, 36);
        check_eq("f8_done", 32'(done8), 1);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < int'(W*H); i++) img[i] = 8'(i + 1);
        for (int k = 0; k < 9; k++) kern[k] = 8'd1;
        bias = 8'd0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; kernel_in = '0; bias_in = '0; pix_valid = 1'b0; pix_data = '0;
        out_ready = 1'b1;
        start8 = 1'b0; kernel8 = '0; bias8 = '0; pix_valid8 = 1'b0; pix_data8 = '0;
        out_ready8 = 1'b1;
        last_hs_cyc = 0;
        #2;
        check_eq("reset_pix_ready", 32'(pix_ready), 0);
        check_eq("reset_out_valid", 32'(out_valid), 0);
        check_eq("reset_out_data", 32'(out_data), 0);
        check_eq("reset_out_last", 32'(out_last), 0);
        check_eq("reset_busy", 32'(busy), 0);
        check_eq("reset_done", 32'(done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ramp image, unit kernel, free-flowing output.
        load_ramp();
        run_frame(0, 0, 0, 0);
        finish_frame(0, 4);

        // Saturating 8x8 frame.
        run_frame8();

        // Output stall mid-frame.
        run_frame(0, 1, 0, 0);
        finish_frame(0, 4);

        // Start pulse and kernel change mid-frame must be ignored.
        for (int k = 0; k < 9; k++) kern[k] = 8'(k);
        bias = 8'd5;
        run_frame(0, 0, 1, 0);
        finish_frame(0, 4);

        // Reset after 7 pixels, then a clean repeat of the first frame.
        load_ramp();
        run_frame(0, 0, 0, 7);
        run_frame(0, 0, 0, 0);
        finish_frame(0, 4);

        // Three back-to-back throttled frames with random content.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < int'(W*H); i++) img[i] = 8'($urandom_range(15));
            for (int k = 0; k < 9; k++) kern[k] = 8'($urandom_range(3));
            bias = 8'($urandom_range(31));
            run_frame(1, 0, 0, 0);
            finish_frame(1, 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
